// File: rtl/regfile_2r1w_clr.sv
// Two-read/one-write register file with registered reads, optional zero register and a
// post-reset clear sequencer. Define REGFILE_WR_BYPASS_EN for write-first forwarding.
module regfile_2r1w_clr #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] Ad_a,
   input  logic [ADDR_W-1:0] Ad_b,
   input  logic [ADDR_W-1:0] Ad_c,
   input  logic [DATA_W-1:0] data_wr,
   input  logic              wr_acc,
   output logic [DATA_W-1:0] data_a,
   output logic [DATA_W-1:0] data_b,
   output logic              ready
);

   localparam int unsigned     DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam bit              ZERO_EN = (ZERO_REG != 0);

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              wr_ok;
   logic              zero_a, zero_b;
   logic              byp_a, byp_b;
   logic [DATA_W-1:0] rd_a, rd_b;

   // State, clear pointer and ready register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
         ready     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         ready     <= (state_d == ST_RUN);
      end
   end

   // Writes to entry 0 vanish when the zero register is enabled
   assign wr_ok  = wr_acc && !(ZERO_EN && (Ad_c == '0));
   assign zero_a = ZERO_EN && (Ad_a == '0);
   assign zero_b = ZERO_EN && (Ad_b == '0);

   // Next state and array write port selection
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      mem_we    = 1'b0;
      mem_waddr = Ad_c;
      mem_wdata = data_wr;
      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == LAST_IDX) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            mem_we = wr_ok;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

`ifdef REGFILE_WR_BYPASS_EN
   assign byp_a = wr_ok && (Ad_c == Ad_a);
   assign byp_b = wr_ok && (Ad_c == Ad_b);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   // Zero-register masking wins over forwarding
   always_comb begin
      rd_a = mem[Ad_a];
      rd_b = mem[Ad_b];
      if (byp_a) rd_a = data_wr;
      if (byp_b) rd_b = data_wr;
      if (zero_a) rd_a = '0;
      if (zero_b) rd_b = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Read data is held at zero until the clear has finished
   always_ff @(posedge clk) begin
      if (rst || (state_q != ST_RUN)) begin
         data_a <= '0;
         data_b <= '0;
      end else begin
         data_a <= rd_a;
         data_b <= rd_b;
      end
   end

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Directed bench for regfile_2r1w_clr: one instance with the zero register, one without.
module tb_regfile_2r1w_clr;

   localparam int unsigned DW = 64;
   localparam int unsigned AW = 5;
`ifdef REGFILE_WR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic [AW-1:0] ad_a, ad_b, ad_c;
   logic [DW-1:0] data_wr;
   logic          wr_acc;
   logic [DW-1:0] da, db, da_nz, db_nz;
   logic          rdy, rdy_nz;

   int checks = 0;
   int errors = 0;

   regfile_2r1w_clr #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .Ad_a(ad_a), .Ad_b(ad_b), .Ad_c(ad_c),
      .data_wr(data_wr), .wr_acc(wr_acc), .data_a(da), .data_b(db), .ready(rdy)
   );

   regfile_2r1w_clr #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut_nz (
      .clk(clk), .rst(rst), .Ad_a(ad_a), .Ad_b(ad_b), .Ad_c(ad_c),
      .data_wr(data_wr), .wr_acc(wr_acc), .data_a(da_nz), .data_b(db_nz), .ready(rdy_nz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a, b, c;
      logic [DW-1:0] wd;
      logic          we;
      logic [DW-1:0] ea, eb, ea_nz, eb_nz;
   } vec_t;

   vec_t vecs[10];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Runs the clear sequence; optionally attempts a write at clear cycle wr_at
   task automatic clear_seq(input int wr_at, output int n);
      n = 0;
      while (n < 200 && !rdy) begin
         wr_acc  = (n == wr_at);
         ad_c    = AW'(3);
         data_wr = 64'hFF;
         ad_a    = AW'(n);
         ad_b    = AW'(31 - n);
         tick;
         n++;
         chk("clear_data_a", da, 64'h0);
         chk("clear_data_b", db, 64'h0);
      end
      wr_acc  = 1'b0;
      data_wr = '0;
      ad_c    = '0;
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         wr_acc = 1'b0;
         ad_a   = AW'(i);
         ad_b   = AW'(31 - i);
         tick;
         chk($sformatf("%s_a%0d", tag, i), da, 64'h0);
         chk($sformatf("%s_b%0d", tag, i), db, 64'h0);
         chk($sformatf("%s_nz_a%0d", tag, i), da_nz, 64'h0);
         chk($sformatf("%s_nz_b%0d", tag, i), db_nz, 64'h0);
      end
   endtask

   initial begin
      #100us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      //           a  b  c   wd                      we  ea                      eb                      ea_nz                   eb_nz
      vecs[0] = '{5'd2,  5'd0,  5'd1,  64'h1,                 1'b1, 64'h0,                 64'h0,                 64'h0,                 64'h0};
      vecs[1] = '{5'd1,  5'd0,  5'd0,  64'h0,                 1'b0, 64'h1,                 64'h0,                 64'h1,                 64'h0};
      vecs[2] = '{5'd1,  5'd2,  5'd0,  64'hDEAD_BEEF,         1'b1, 64'h1,                 64'h0,                 64'h1,                 64'h0};
      vecs[3] = '{5'd0,  5'd0,  5'd0,  64'h0,                 1'b0, 64'h0,                 64'h0,                 64'hDEAD_BEEF,         64'hDEAD_BEEF};
      vecs[4] = '{5'd0,  5'd1,  5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0,               64'h1,                 64'hDEAD_BEEF,         64'h1};
      vecs[5] = '{5'd31, 5'd31, 5'd7,  64'h0123_4567_89AB_CDEF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[6] = '{5'd7,  5'd31, 5'd1,  64'h5555_5555_5555_5555, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[7] = '{5'd1,  5'd7,  5'd0,  64'h0,                 1'b0, 64'h5555_5555_5555_5555, 64'h0123_4567_89AB_CDEF, 64'h5555_5555_5555_5555, 64'h0123_4567_89AB_CDEF};
      vecs[8] = '{5'd31, 5'd1,  5'd2,  64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555};
      vecs[9] = '{5'd2,  5'd0,  5'd0,  64'h0,                 1'b0, 64'h0,                 64'h0,                 64'h0,                 64'hDEAD_BEEF};

      rst = 1'b1; wr_acc = 1'b0; ad_a = '0; ad_b = '0; ad_c = '0; data_wr = '0;
      tick;
      tick;
      chk("rst_ready", 64'(rdy), 64'h0);
      chk("rst_ready_nz", 64'(rdy_nz), 64'h0);
      chk("rst_data_a", da, 64'h0);
      chk("rst_data_b", db, 64'h0);

      // Initial clear, with a write attempt at clear cycle 10
      rst = 1'b0;
      clear_seq(10, n);
      chk("clear_len", 64'(n), 64'd32);
      chk("ready_up", 64'(rdy), 64'h1);
      chk("ready_up_nz", 64'(rdy_nz), 64'h1);
      check_all_zero("init");

      for (int i = 0; i < 10; i++) begin
         ad_a = vecs[i].a; ad_b = vecs[i].b; ad_c = vecs[i].c;
         data_wr = vecs[i].wd; wr_acc = vecs[i].we;
         tick;
         chk($sformatf("vec%0d_a", i), da, vecs[i].ea);
         chk($sformatf("vec%0d_b", i), db, vecs[i].eb);
         chk($sformatf("vec%0d_nz_a", i), da_nz, vecs[i].ea_nz);
         chk($sformatf("vec%0d_nz_b", i), db_nz, vecs[i].eb_nz);
      end

      // Same-cycle read/write hazard on entry 5
      ad_a = '0; ad_b = '0; ad_c = AW'(5); data_wr = 64'hA; wr_acc = 1'b1;
      tick;
      ad_a = AW'(5); ad_b = AW'(5); data_wr = 64'hB;
      tick;
      chk("haz_a", da, BYP ? 64'hB : 64'hA);
      chk("haz_b", db, BYP ? 64'hB : 64'hA);
      chk("haz_nz_a", da_nz, BYP ? 64'hB : 64'hA);
      wr_acc = 1'b0;
      tick;
      chk("haz_next_a", da, 64'hB);
      chk("haz_next_b", db, 64'hB);

      // Zero register masks forwarding; plain entry 0 forwards when enabled
      ad_a = '0; ad_b = AW'(5); ad_c = '0; data_wr = 64'h77; wr_acc = 1'b1;
      tick;
      chk("zfwd_a", da, 64'h0);
      chk("zfwd_b", db, 64'hB);
      chk("zfwd_nz_a", da_nz, BYP ? 64'h77 : 64'hDEAD_BEEF);
      wr_acc = 1'b0; ad_b = '0;
      tick;
      chk("z_after_a", da, 64'h0);
      chk("z_after_b", db, 64'h0);
      chk("z_after_nz_a", da_nz, 64'h77);
      chk("z_after_nz_b", db_nz, 64'h77);

      // Reset during clear restarts it from entry 0
      rst = 1'b1;
      tick;
      chk("rst2_ready", 64'(rdy), 64'h0);
      chk("rst2_data_a", da, 64'h0);
      rst = 1'b0;
      ad_a = AW'(5); ad_b = AW'(1);
      for (int i = 0; i < 20; i++) begin
         tick;
         chk($sformatf("partial_ready%0d", i), 64'(rdy), 64'h0);
      end
      rst = 1'b1;
      tick;
      chk("mid_rst_ready", 64'(rdy), 64'h0);
      chk("mid_rst_data_a", da, 64'h0);
      rst = 1'b0;
      clear_seq(-1, n);
      chk("reclear_len", 64'(n), 64'd32);
      chk("reclear_ready", 64'(rdy), 64'h1);
      check_all_zero("post");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
